// File: rtl/adder_host_regfile.sv
`default_nettype none
// ============================================================================
// Module   : adder_host_regfile
// Purpose  : Host-facing control/status register file for the vector-adder
//            accelerator. Decodes single-word host read/write requests into
//            CTRL, CYCLES, LENGTH, A_ADDR, B_ADDR and C_ADDR, drives the
//            downstream sequencer and captures its finish / cycle count.
// Ports    : clock, reset                 - clock and synchronous active-high reset
//            host_req_*                   - host request (valid/opcode/addr/value)
//            host_req_deq                 - request accepted this cycle
//            host_resp_valid/_bits        - read response (1-cycle pulse / held data)
//            launch, length, a_addr,
//            b_addr, c_addr               - register contents to the sequencer
//            finish                       - completion pulse from the sequencer
//            event_counter_valid/_value   - cycle-count capture from the sequencer
// Revision : 1.0 - initial release
// ============================================================================
module adder_host_regfile #(
    parameter int HOST_ADDR_BITS = 8,
    parameter int HOST_DATA_BITS = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      host_req_valid,
    input  logic                      host_req_opcode,
    input  logic [HOST_ADDR_BITS-1:0] host_req_addr,
    input  logic [HOST_DATA_BITS-1:0] host_req_value,
    output logic                      host_req_deq,
    output logic                      host_resp_valid,
    output logic [HOST_DATA_BITS-1:0] host_resp_bits,
    output logic                      launch,
    input  logic                      finish,
    input  logic                      event_counter_valid,
    input  logic [HOST_DATA_BITS-1:0] event_counter_value,
    output logic [HOST_DATA_BITS-1:0] length,
    output logic [HOST_DATA_BITS-1:0] a_addr,
    output logic [HOST_DATA_BITS-1:0] b_addr,
    output logic [HOST_DATA_BITS-1:0] c_addr
);

    localparam int c_IDX_BITS = HOST_ADDR_BITS - 2;

    localparam logic [c_IDX_BITS-1:0] c_IDX_CTRL   = c_IDX_BITS'(0);
    localparam logic [c_IDX_BITS-1:0] c_IDX_CYCLES = c_IDX_BITS'(1);
    localparam logic [c_IDX_BITS-1:0] c_IDX_LENGTH = c_IDX_BITS'(2);
    localparam logic [c_IDX_BITS-1:0] c_IDX_A_ADDR = c_IDX_BITS'(3);
    localparam logic [c_IDX_BITS-1:0] c_IDX_B_ADDR = c_IDX_BITS'(4);
    localparam logic [c_IDX_BITS-1:0] c_IDX_C_ADDR = c_IDX_BITS'(5);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                      r_launch;
    logic                      r_done;
    logic [HOST_DATA_BITS-1:0] r_cycles;
    logic [HOST_DATA_BITS-1:0] r_length;
    logic [HOST_DATA_BITS-1:0] r_a_addr;
    logic [HOST_DATA_BITS-1:0] r_b_addr;
    logic [HOST_DATA_BITS-1:0] r_c_addr;
    logic [HOST_DATA_BITS-1:0] r_resp_bits;

    logic                      w_deq;
    logic                      w_resp_valid;
    logic                      w_wr_en;
    logic                      w_rd_en;
    logic [c_IDX_BITS-1:0]     w_idx;
    logic [HOST_DATA_BITS-1:0] w_rd_data;

    // Byte-lane bits of the address carry no meaning: accesses are word-only.
    logic [1:0] w_unused_addr_bits;
    assign w_unused_addr_bits = host_req_addr[1:0];

    assign w_idx = host_req_addr[HOST_ADDR_BITS-1:2];

    // ------------------------------------------------------------------------
    // Request / response handshake FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_deq        = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_deq = host_req_valid;
                if (host_req_valid && !host_req_opcode) begin
                    w_state_next = ST_READ;
                end
            end
            ST_READ: begin
                w_resp_valid = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Gating with reset drops a response whose READ cycle coincides with reset,
    // and keeps the handshake quiet for the whole reset period.
    assign host_req_deq    = w_deq & ~reset;
    assign host_resp_valid = w_resp_valid & ~reset;
    assign host_resp_bits  = r_resp_bits;

    // While busy, writes are still dequeued but have no effect.
    assign w_wr_en = w_deq & host_req_opcode & ~r_launch;
    assign w_rd_en = w_deq & ~host_req_opcode;

    // ------------------------------------------------------------------------
    // Read data mux (pre-edge register values)
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_data = '0;
        case (w_idx)
            c_IDX_CTRL:   w_rd_data = {{(HOST_DATA_BITS-2){1'b0}}, r_done, r_launch};
            c_IDX_CYCLES: w_rd_data = r_cycles;
            c_IDX_LENGTH: w_rd_data = r_length;
            c_IDX_A_ADDR: w_rd_data = r_a_addr;
            c_IDX_B_ADDR: w_rd_data = r_b_addr;
            c_IDX_C_ADDR: w_rd_data = r_c_addr;
            default:      w_rd_data = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_launch    <= 1'b0;
            r_done      <= 1'b0;
            r_cycles    <= '0;
            r_length    <= '0;
            r_a_addr    <= '0;
            r_b_addr    <= '0;
            r_c_addr    <= '0;
            r_resp_bits <= '0;
        end else begin
            if (w_wr_en) begin
                case (w_idx)
                    c_IDX_CTRL: begin
                        // A same-cycle finish overrides a launch request.
                        if (host_req_value[0] && !finish) begin
                            r_launch <= 1'b1;
                            r_done   <= 1'b0;
                            r_cycles <= '0;
                        end
                    end
                    c_IDX_LENGTH: r_length <= host_req_value;
                    c_IDX_A_ADDR: r_a_addr <= host_req_value;
                    c_IDX_B_ADDR: r_b_addr <= host_req_value;
                    c_IDX_C_ADDR: r_c_addr <= host_req_value;
                    default: begin
                        // CYCLES is read-only; unmapped words are ignored.
                    end
                endcase
            end

            if (event_counter_valid) begin
                r_cycles <= event_counter_value;
            end

            if (finish) begin
                r_launch <= 1'b0;
                r_done   <= 1'b1;
            end

            if (w_rd_en) begin
                r_resp_bits <= w_rd_data;
            end
        end
    end

    assign launch = r_launch;
    assign length = r_length;
    assign a_addr = r_a_addr;
    assign b_addr = r_b_addr;
    assign c_addr = r_c_addr;

endmodule
`default_nettype wire

// File: doc/adder_host_regfile.md
# adder_host_regfile

Host-facing control/status register file for the vector-adder accelerator. It decodes single-word host read/write requests into six 32-bit registers. It drives the `launch`, `length`, `a_addr`, `b_addr` and `c_addr` inputs of the memory/compute sequencer directly downstream, and captures that sequencer's `finish` and `event_counter_*` outputs for the host to poll.

## Interface
Parameters:
- HOST_ADDR_BITS, 8, width of host register byte address
- HOST_DATA_BITS, 32, width of host data and of every register

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- host_req_valid  in  1  host request present
- host_req_opcode  in  1  1 = write, 0 = read
- host_req_addr  in  HOST_ADDR_BITS  byte address
- host_req_value  in  HOST_DATA_BITS  write data
- host_req_deq  out  1  request accepted (dequeued) this cycle
- host_resp_valid  out  1  read response valid (1-cycle pulse)
- host_resp_bits  out  HOST_DATA_BITS  read data
- launch  out  1  start level to sequencer
- finish  in  1  1-cycle completion pulse from sequencer
- event_counter_valid  in  1  cycle-count capture strobe
- event_counter_value  in  HOST_DATA_BITS  cycle count
- length, a_addr, b_addr, c_addr  out  HOST_DATA_BITS each  register contents

## Operation
Register map (word index = host_req_addr[HOST_ADDR_BITS-1:2]; addr[1:0] ignored):
- 0x00 CTRL: bit0 LAUNCH (RW), bit1 DONE (RO, sticky), bits[31:2] read 0
- 0x04 CYCLES: RO; loaded from event_counter_value
- 0x08 LENGTH, 0x0C A_ADDR, 0x10 B_ADDR, 0x14 C_ADDR: RW
- Any other index: reads return 0, writes ignored.

Behaviour:
- busy = LAUNCH. `launch` output = LAUNCH bit; `length`, `a_addr`, `b_addr`, `c_addr` = register contents.
- Write CTRL with value[0]=1 while not busy: LAUNCH<=1, DONE<=0, CYCLES<=0. Write with value[0]=0 while not busy: no change.
- While busy, every host write (any address) is accepted and dropped, with no register change.
- finish=1: LAUNCH<=0, DONE<=1. finish has priority over any same-cycle host access.
- event_counter_valid=1: CYCLES<=event_counter_value, independent of busy.
- Writes to CYCLES or to DONE are ignored.

FSM states: IDLE, READ.
- IDLE: host_req_deq = host_req_valid. On deq with a write, the write is applied at that edge and the FSM stays in IDLE. On deq with a read, the addressed word (pre-edge value) is latched into a response register and the FSM goes to READ.
- READ: host_req_deq=0; host_resp_valid=1; host_resp_bits=latched word; next state IDLE.

## Timing
- Reset: state IDLE; all registers 0; launch=0, host_req_deq=0, host_resp_valid=0, host_resp_bits=0.
- Write: accepted in the deq cycle; the new value is visible on outputs the next cycle. One write per cycle sustained.
- Read: response one cycle after deq; maximum one read per 2 cycles.
- A read deq'd in the same cycle as finish returns the pre-finish CTRL value (LAUNCH=1, DONE=0).
- Same-cycle event_counter_valid and a CYCLES read: the read returns the old value.
- Reset asserted mid-READ: the response is dropped, and host_resp_valid=0 in the following cycle.
- host_resp_bits holds its last value between responses.

## Test plan
- Reset, then read 0x00, 0x04, 0x08 -> each returns 0; host_resp_valid exactly one cycle after each deq; launch=0.
- Write LENGTH=16, A_ADDR=0x100, B_ADDR=0x200, C_ADDR=0x300, then read all back -> outputs and readbacks match on the cycle after each write.
- Write CTRL=1 -> launch=1 the next cycle. Write LENGTH=5 while busy -> LENGTH stays 16. Pulse event_counter_valid with value 0x2A plus finish -> launch=0, CTRL reads 0x2, CYCLES reads 0x2A.
- Host writes CTRL=1 in the same cycle finish pulses while busy -> LAUNCH=0, DONE=1 (finish wins).
- Read 0x3C, then write 0x3C=0xFFFFFFFF, then read 0x3C -> both reads return 0; no other register changes. Write 0x04=7 -> CYCLES unchanged.
- Issue a read deq, then assert reset in the READ cycle -> no host_resp_valid follows; all registers are 0 after reset.
